dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Sits directly downstream of the data-memory cache/controller. It takes the NUM_CHANNELS parallel memory request channels the cache drives and serializes them onto one external data-memory port.
- Arbitration is round-robin. One external transaction is in flight at a time.
- Each completion is returned to the originating channel as a one-cycle ready pulse. This matches the channel handshake the cache expects.

Parameters:
ADDR_BITS, 8, address width of channels and external port
DATA_BITS, 8, data width of channels and external port
NUM_CHANNELS, 4, number of upstream request channels

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
chan_read_valid  input  [NUM_CHANNELS-1:0]  per-channel read request, held until ready
chan_read_address  input  [ADDR_BITS-1:0] x NUM_CHANNELS  read address per channel
chan_read_ready  output  [NUM_CHANNELS-1:0]  one-cycle read completion pulse
chan_read_data  output  [DATA_BITS-1:0] x NUM_CHANNELS  read data per channel, valid when ready pulses
chan_write_valid  input  [NUM_CHANNELS-1:0]  per-channel write request, held until ready
chan_write_address  input  [ADDR_BITS-1:0] x NUM_CHANNELS  write address per channel
chan_write_data  input  [DATA_BITS-1:0] x NUM_CHANNELS  write data per channel
chan_write_ready  output  [NUM_CHANNELS-1:0]  one-cycle write completion pulse
ext_valid  output  1  external request active
ext_write  output  1  1 = write, 0 = read; stable while ext_valid
ext_address  output  [ADDR_BITS-1:0]  external address; stable while ext_valid
ext_wdata  output  [DATA_BITS-1:0]  external write data; stable while ext_valid
ext_ready  input  1  external completion; first rising edge sampled high in WAIT ends the transaction
ext_rdata  input  [DATA_BITS-1:0]  external read data, sampled with ext_ready
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (asynchronous, immediate):
  - All outputs go to 0, including every chan_read_data entry.
  - State goes to IDLE and the round-robin pointer goes to 0.
  - A transaction in flight at reset is abandoned; no ready pulse is issued for it.
- States: IDLE, WAIT, RESPOND. All outputs are registered.
- A channel is requesting when chan_read_valid[c] or chan_write_valid[c] is high.
- IDLE:
  - If no channel is requesting, stay in IDLE.
  - Otherwise grant the first requesting channel, searching from pointer upward and wrapping modulo NUM_CHANNELS.
  - Latch the grant index. Set the pointer to (grant+1) mod NUM_CHANNELS.
  - Drive ext_valid=1, ext_address, ext_write and ext_wdata from the granted channel, then go to WAIT.
  - If a channel asserts both read and write valid, the read is served. The write stays pending and is served on a later grant.
- WAIT:
  - Hold all ext_* outputs stable.
  - On ext_ready=1:
    - drive ext_valid=0;
    - for a read, set chan_read_data[grant]=ext_rdata and chan_read_ready[grant]=1;
    - for a write, set chan_write_ready[grant]=1;
    - go to RESPOND.
  - ext_ready is ignored outside WAIT.
- RESPOND:
  - Clear both ready bits of the granted channel and go to IDLE.
  - Request valids are not evaluated in this cycle, because the granted channel's valid is still high here.
  - The ready pulse is therefore exactly one cycle.
- chan_read_data[c] holds its last value until channel c's next read completion. Write completions never change it.
- Latency:
  - Request sampled at edge N gives ext_valid high after edge N.
  - ext_ready sampled at edge M gives the channel ready high in the cycle after edge M.
  - The earliest next grant is edge M+2.
  - Minimum turnaround is 3 cycles with zero-wait memory (ext_ready tied high).
- Fairness: with all channels requesting continuously, grants go 0,1,2,3,0,... No channel waits more than NUM_CHANNELS-1 transactions.
- A channel dropping valid while it is granted (protocol violation) does not abort the transaction; completion is still pulsed.
- busy is combinational from state.

Test Plan:
1. Single read: chan 2 reads addr 0x34, ext_ready returned 2 cycles after ext_valid with ext_rdata 0xA5. Required: ext_address=0x34, ext_write=0; chan_read_ready[2] high for exactly 1 cycle; chan_read_data[2]=0xA5; busy low afterwards.
2. Single write: chan 1 writes 0x7E to 0x10, ext_ready tied high. Required: ext_write=1, ext_address=0x10, ext_wdata=0x7E; chan_write_ready[1] pulses once; chan_read_data unchanged; 3-cycle turnaround.
3. Round-robin: chans 0-3 all read simultaneously, each re-requesting right after its ready pulse. Required: grant order 0,1,2,3,0,1; every channel gets its own address's data.
4. Back-to-back same channel: chan 0 drops valid after ready and reasserts 1 cycle later, with chan 3 also requesting. Required: no duplicate completion for the first request; chan 3 is granted before chan 0's second request.
5. Reset mid-transaction: assert reset while in WAIT with ext_valid high. Required: ext_valid and busy go low immediately without waiting for a clock edge; no ready pulse. After release, a new chan 1 request is granted first (pointer=0, chan 0 idle).
6. Long stall: ext_ready held low for 20 cycles, then held high for 3 cycles. Required: ext outputs stable for 20 cycles; exactly one completion pulse; the next grant is not taken until IDLE.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// Channel-side and external-memory-side signals of the data-memory port arbiter.
// The arbiter connects through the slave modport; the cache/memory environment uses master.
interface dmem_port_arbiter_if #(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int NUM_CHANNELS = 4
);
    logic [NUM_CHANNELS-1:0]                chan_read_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] chan_read_address;
    logic [NUM_CHANNELS-1:0]                chan_read_ready;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] chan_read_data;
    logic [NUM_CHANNELS-1:0]                chan_write_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] chan_write_address;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] chan_write_data;
    logic [NUM_CHANNELS-1:0]                chan_write_ready;

    logic                 ext_valid;
    logic                 ext_write;
    logic [ADDR_BITS-1:0] ext_address;
    logic [DATA_BITS-1:0] ext_wdata;
    logic                 ext_ready;
    logic [DATA_BITS-1:0] ext_rdata;

    modport slave (
        input  chan_read_valid,
        input  chan_read_address,
        output chan_read_ready,
        output chan_read_data,
        input  chan_write_valid,
        input  chan_write_address,
        input  chan_write_data,
        output chan_write_ready,
        output ext_valid,
        output ext_write,
        output ext_address,
        output ext_wdata,
        input  ext_ready,
        input  ext_rdata
    );

    modport master (
        output chan_read_valid,
        output chan_read_address,
        input  chan_read_ready,
        input  chan_read_data,
        output chan_write_valid,
        output chan_write_address,
        output chan_write_data,
        input  chan_write_ready,
        input  ext_valid,
        input  ext_write,
        input  ext_address,
        input  ext_wdata,
        output ext_ready,
        output ext_rdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin serializer of NUM_CHANNELS read/write request channels onto one
// external data-memory port, one transaction in flight, one-cycle completion pulses.
module dmem_port_arbiter #(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int NUM_CHANNELS = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    dmem_port_arbiter_if.slave  bus,
    output logic                o_busy
);
    localparam int PW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t                                 r_state;
    logic [PW-1:0]                          r_ptr;
    logic [PW-1:0]                          r_grant;
    logic                                   r_ext_valid;
    logic                                   r_ext_write;
    logic [ADDR_BITS-1:0]                   r_ext_address;
    logic [DATA_BITS-1:0]                   r_ext_wdata;
    logic [NUM_CHANNELS-1:0]                r_rd_ready;
    logic [NUM_CHANNELS-1:0]                r_wr_ready;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] r_rd_data;

    state_t                                 w_state_next;
    logic [PW-1:0]                          w_ptr_next;
    logic [PW-1:0]                          w_grant_next;
    logic                                   w_ext_valid_next;
    logic                                   w_ext_write_next;
    logic [ADDR_BITS-1:0]                   w_ext_address_next;
    logic [DATA_BITS-1:0]                   w_ext_wdata_next;
    logic [NUM_CHANNELS-1:0]                w_rd_ready_next;
    logic [NUM_CHANNELS-1:0]                w_wr_ready_next;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] w_rd_data_next;

    logic [NUM_CHANNELS-1:0]                w_req;
    logic [NUM_CHANNELS-1:0][PW-1:0]        w_rr_idx;
    logic                                   w_found;
    logic [PW-1:0]                          w_grant;
    logic [PW-1:0]                          w_grant_inc;

    assign w_req = bus.chan_read_valid | bus.chan_write_valid;

    // w_rr_idx[k] is the channel examined k-th when searching upward from r_ptr.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_rr
            logic [PW:0] w_sum;
            assign w_sum = {1'b0, r_ptr} + (PW+1)'(gi);
            assign w_rr_idx[gi] = (w_sum >= (PW+1)'(NUM_CHANNELS))
                                ? PW'(w_sum - (PW+1)'(NUM_CHANNELS))
                                : w_sum[PW-1:0];
        end
    endgenerate

    // Scan from the far end so the nearest requester to r_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
            if (w_req[w_rr_idx[k]]) begin
                w_found = 1'b1;
                w_grant = w_rr_idx[k];
            end
        end
    end

    assign w_grant_inc = (w_grant == PW'(NUM_CHANNELS - 1)) ? '0 : w_grant + PW'(1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_grant       <= '0;
            r_ext_valid   <= 1'b0;
            r_ext_write   <= 1'b0;
            r_ext_address <= '0;
            r_ext_wdata   <= '0;
            r_rd_ready    <= '0;
            r_wr_ready    <= '0;
            r_rd_data     <= '0;
        end else begin
            r_state       <= w_state_next;
            r_ptr         <= w_ptr_next;
            r_grant       <= w_grant_next;
            r_ext_valid   <= w_ext_valid_next;
            r_ext_write   <= w_ext_write_next;
            r_ext_address <= w_ext_address_next;
            r_ext_wdata   <= w_ext_wdata_next;
            r_rd_ready    <= w_rd_ready_next;
            r_wr_ready    <= w_wr_ready_next;
            r_rd_data     <= w_rd_data_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_found) w_state_next = S_WAIT;
            S_WAIT:    if (bus.ext_ready) w_state_next = S_RESPOND;
            S_RESPOND: w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ptr_next         = r_ptr;
        w_grant_next       = r_grant;
        w_ext_valid_next   = r_ext_valid;
        w_ext_write_next   = r_ext_write;
        w_ext_address_next = r_ext_address;
        w_ext_wdata_next   = r_ext_wdata;
        w_rd_ready_next    = r_rd_ready;
        w_wr_ready_next    = r_wr_ready;
        w_rd_data_next     = r_rd_data;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant_next     = w_grant;
                    w_ptr_next       = w_grant_inc;
                    w_ext_valid_next = 1'b1;
                    // A pending read takes precedence; the channel's write waits for a later grant.
                    if (bus.chan_read_valid[w_grant]) begin
                        w_ext_write_next   = 1'b0;
                        w_ext_address_next = bus.chan_read_address[w_grant];
                        w_ext_wdata_next   = '0;
                    end else begin
                        w_ext_write_next   = 1'b1;
                        w_ext_address_next = bus.chan_write_address[w_grant];
                        w_ext_wdata_next   = bus.chan_write_data[w_grant];
                    end
                end
            end
            S_WAIT: begin
                if (bus.ext_ready) begin
                    w_ext_valid_next = 1'b0;
                    if (r_ext_write) begin
                        w_wr_ready_next[r_grant] = 1'b1;
                    end else begin
                        w_rd_ready_next[r_grant] = 1'b1;
                        w_rd_data_next[r_grant]  = bus.ext_rdata;
                    end
                end
            end
            S_RESPOND: begin
                w_rd_ready_next = '0;
                w_wr_ready_next = '0;
            end
            default: ;
        endcase
    end

    assign bus.ext_valid        = r_ext_valid;
    assign bus.ext_write        = r_ext_write;
    assign bus.ext_address      = r_ext_address;
    assign bus.ext_wdata        = r_ext_wdata;
    assign bus.chan_read_ready  = r_rd_ready;
    assign bus.chan_write_ready = r_wr_ready;

    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_rdata
            assign bus.chan_read_data[gi] = r_rd_data[gi];
        end
    endgenerate

    assign o_busy = (r_state != S_IDLE);
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: single read/write, round-robin order,
// same-channel re-request, asynchronous reset mid-transaction and a long stall.
`timescale 1ns/1ps
module tb_dmem_port_arbiter;
    localparam int AB = 8;
    localparam int DB = 8;
    localparam int NC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC)) bif ();

    dmem_port_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .bus    (bif),
        .o_busy (busy)
    );

    // Memory responder: ready after resp_delay cycles of ext_valid, data = address ^ 0x91.
    int   resp_delay = 0;
    bit   resp_en    = 1'b1;
    logic man_ready  = 1'b0;
    logic resp_ready = 1'b0;
    int   resp_cnt   = 0;

    always @(negedge clk) begin
        if (bif.ext_valid) begin
            resp_ready = (resp_cnt >= resp_delay);
            resp_cnt++;
        end else begin
            resp_ready = 1'b0;
            resp_cnt   = 0;
        end
    end

    assign bif.ext_ready = resp_en ? resp_ready : man_ready;
    assign bif.ext_rdata = bif.ext_address ^ 8'h91;

    // Monitor: logs grants and completions, one line per transaction event.
    logic [AB-1:0] grant_q[$];
    bit            prev_valid  = 1'b0;
    int            rd_pulses[NC] = '{default: 0};
    int            wr_pulses[NC] = '{default: 0};
    int            long_pulses = 0;
    logic [NC-1:0] prev_rd = '0;
    logic [NC-1:0] prev_wr = '0;

    always @(negedge clk) begin
        if (bif.ext_valid && !prev_valid) begin
            grant_q.push_back(bif.ext_address);
            $display("%0t grant addr=%02h write=%0b wdata=%02h", $time, bif.ext_address, bif.ext_write, bif.ext_wdata);
        end
        prev_valid = bif.ext_valid;
        for (int c = 0; c < NC; c++) begin
            if (bif.chan_read_ready[c]) begin
                rd_pulses[c]++;
                if (prev_rd[c]) long_pulses++;
                $display("%0t read  done chan=%0d data=%02h", $time, c, bif.chan_read_data[c]);
            end
            if (bif.chan_write_ready[c]) begin
                wr_pulses[c]++;
                if (prev_wr[c]) long_pulses++;
                $display("%0t write done chan=%0d", $time, c);
            end
        end
        prev_rd = bif.chan_read_ready;
        prev_wr = bif.chan_write_ready;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!bif.ext_valid && k < 50) begin
            step();
            k++;
        end
        check_val({tag, "_ext_valid_seen"}, 32'(bif.ext_valid), 32'd1);
    endtask

    task automatic wait_rd(input int c, input string tag);
        int k = 0;
        while (!bif.chan_read_ready[c] && k < 60) begin
            step();
            k++;
        end
        check_val({tag, "_read_ready_seen"}, 32'(bif.chan_read_ready[c]), 32'd1);
    endtask

    initial begin
        int            k;
        int            bc;
        int            done;
        int            phase;
        int            base;
        int            b0;
        int            b3;
        int            bad;
        logic [NC-1:0] seen;
        logic [7:0]    e;

        bif.chan_read_valid    = '0;
        bif.chan_write_valid   = '0;
        bif.chan_read_address  = '0;
        bif.chan_write_address = '0;
        bif.chan_write_data    = '0;

        // Reset state
        step();
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_ext_valid", 32'(bif.ext_valid), 32'd0);
        check_val("rst_rd_ready", 32'(bif.chan_read_ready), 32'd0);
        check_val("rst_wr_ready", 32'(bif.chan_write_ready), 32'd0);
        check_val("rst_rd_data", 32'(bif.chan_read_data), 32'd0);
        rst = 1'b0;

        // 1: single read, chan 2, ready 2 cycles after ext_valid
        resp_en = 1'b1;
        resp_delay = 2;
        bif.chan_read_address[2] = 8'h34;
        bif.chan_read_valid[2] = 1'b1;
        wait_valid("t1");
        check_val("t1_addr", 32'(bif.ext_address), 32'h34);
        check_val("t1_write", 32'(bif.ext_write), 32'd0);
        wait_rd(2, "t1");
        check_val("t1_rdata", 32'(bif.chan_read_data[2]), 32'hA5);
        bif.chan_read_valid[2] = 1'b0;
        step();
        check_val("t1_ready_one_cycle", 32'(bif.chan_read_ready[2]), 32'd0);
        check_val("t1_busy_after", 32'(busy), 32'd0);

        // 2: single write, chan 1, zero-wait memory
        resp_delay = 0;
        base = wr_pulses[1];
        bif.chan_write_address[1] = 8'h10;
        bif.chan_write_data[1] = 8'h7E;
        bif.chan_write_valid[1] = 1'b1;
        wait_valid("t2");
        check_val("t2_write", 32'(bif.ext_write), 32'd1);
        check_val("t2_addr", 32'(bif.ext_address), 32'h10);
        check_val("t2_wdata", 32'(bif.ext_wdata), 32'h7E);
        bc = 0;
        k = 0;
        while (busy && k < 20) begin
            bc++;
            if (bif.chan_write_ready[1]) bif.chan_write_valid[1] = 1'b0;
            step();
            k++;
        end
        check_val("t2_busy_cycles", 32'(bc), 32'd2);
        check_val("t2_wr_pulses", 32'(wr_pulses[1] - base), 32'd1);
        check_val("t2_rd_data_kept", 32'(bif.chan_read_data), 32'h00A50000);

        // 3: round-robin with all four channels holding read valid
        do_reset();
        base = grant_q.size();
        for (int c = 0; c < NC; c++) bif.chan_read_address[c] = 8'h40 + 8'(c);
        bif.chan_read_valid = '1;
        done = 0;
        k = 0;
        while (done < 6 && k < 100) begin
            step();
            k++;
            for (int c = 0; c < NC; c++) begin
                if (bif.chan_read_ready[c]) begin
                    e = (8'h40 + 8'(c)) ^ 8'h91;
                    check_val($sformatf("t3_data_c%0d", c), 32'(bif.chan_read_data[c]), 32'(e));
                    done++;
                end
            end
        end
        bif.chan_read_valid = '0;
        check_val("t3_completions", 32'(done), 32'd6);
        repeat (4) step();
        check_val("t3_grant_count", 32'(grant_q.size() - base), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (base + i < grant_q.size()) begin
                e = 8'h40 + 8'(i % 4);
                check_val($sformatf("t3_grant%0d", i), 32'(grant_q[base + i]), 32'(e));
            end
        end

        // 4: chan 0 drops valid after ready, reasserts a cycle later; chan 3 waiting
        do_reset();
        base = grant_q.size();
        b0 = rd_pulses[0];
        b3 = rd_pulses[3];
        bif.chan_read_address[0] = 8'h50;
        bif.chan_read_address[3] = 8'h53;
        bif.chan_read_valid[0] = 1'b1;
        bif.chan_read_valid[3] = 1'b1;
        phase = 0;
        k = 0;
        while (phase < 3 && k < 100) begin
            step();
            k++;
            if (phase == 1) begin
                bif.chan_read_valid[0] = 1'b1;
                phase = 2;
            end else if (bif.chan_read_ready[0]) begin
                bif.chan_read_valid[0] = 1'b0;
                phase = (phase == 0) ? 1 : 3;
            end
            if (bif.chan_read_ready[3]) bif.chan_read_valid[3] = 1'b0;
        end
        check_val("t4_done", 32'(phase), 32'd3);
        repeat (3) step();
        check_val("t4_c0_pulses", 32'(rd_pulses[0] - b0), 32'd2);
        check_val("t4_c3_pulses", 32'(rd_pulses[3] - b3), 32'd1);
        check_val("t4_grant_count", 32'(grant_q.size() - base), 32'd3);
        if (grant_q.size() - base == 3) begin
            check_val("t4_grant0", 32'(grant_q[base]), 32'h50);
            check_val("t4_grant1", 32'(grant_q[base + 1]), 32'h53);
            check_val("t4_grant2", 32'(grant_q[base + 2]), 32'h50);
        end

        // 5: asynchronous reset while in WAIT
        resp_en = 1'b0;
        man_ready = 1'b0;
        b0 = rd_pulses[0];
        bif.chan_read_address[0] = 8'h60;
        bif.chan_read_valid[0] = 1'b1;
        wait_valid("t5");
        step();
        check_val("t5_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_val("t5_ext_valid_async", 32'(bif.ext_valid), 32'd0);
        check_val("t5_busy_async", 32'(busy), 32'd0);
        check_val("t5_rd_data_cleared", 32'(bif.chan_read_data), 32'd0);
        bif.chan_read_valid[0] = 1'b0;
        step();
        step();
        rst = 1'b0;
        seen = '0;
        repeat (3) begin
            step();
            seen = seen | bif.chan_read_ready | bif.chan_write_ready;
        end
        check_val("t5_no_pulse", 32'(seen), 32'd0);
        check_val("t5_c0_pulses", 32'(rd_pulses[0] - b0), 32'd0);
        resp_en = 1'b1;
        resp_delay = 0;
        bif.chan_read_address[1] = 8'h61;
        bif.chan_read_valid[1] = 1'b1;
        wait_valid("t5b");
        check_val("t5_new_grant_addr", 32'(bif.ext_address), 32'h61);
        wait_rd(1, "t5b");
        check_val("t5_new_rdata", 32'(bif.chan_read_data[1]), 32'hF0);
        bif.chan_read_valid[1] = 1'b0;
        step();

        // 6: long stall with a second channel queued behind
        resp_en = 1'b0;
        man_ready = 1'b0;
        b0 = rd_pulses[2];
        bif.chan_read_address[2] = 8'h72;
        bif.chan_read_valid[2] = 1'b1;
        bif.chan_write_address[3] = 8'h83;
        bif.chan_write_data[3] = 8'h3C;
        bif.chan_write_valid[3] = 1'b1;
        wait_valid("t6");
        check_val("t6_first_addr", 32'(bif.ext_address), 32'h72);
        bad = 0;
        repeat (20) begin
            step();
            if (!bif.ext_valid || bif.ext_address != 8'h72 || bif.ext_write || !busy
                || bif.chan_read_ready != '0 || bif.chan_write_ready != '0) bad++;
        end
        check_val("t6_stall_stable", 32'(bad), 32'd0);
        man_ready = 1'b1;
        step();
        check_val("t6_ready_pulse", 32'(bif.chan_read_ready[2]), 32'd1);
        check_val("t6_rdata", 32'(bif.chan_read_data[2]), 32'hE3);
        check_val("t6_valid_dropped", 32'(bif.ext_valid), 32'd0);
        bif.chan_read_valid[2] = 1'b0;
        step();
        check_val("t6_idle_busy", 32'(busy), 32'd0);
        check_val("t6_idle_no_grant", 32'(bif.ext_valid), 32'd0);
        check_val("t6_pulse_ended", 32'(bif.chan_read_ready[2]), 32'd0);
        step();
        check_val("t6_next_grant", 32'(bif.ext_valid), 32'd1);
        check_val("t6_next_write", 32'(bif.ext_write), 32'd1);
        check_val("t6_next_addr", 32'(bif.ext_address), 32'h83);
        check_val("t6_next_wdata", 32'(bif.ext_wdata), 32'h3C);
        man_ready = 1'b0;
        resp_en = 1'b1;
        k = 0;
        while (!bif.chan_write_ready[3] && k < 20) begin
            step();
            k++;
        end
        check_val("t6_write_done", 32'(bif.chan_write_ready[3]), 32'd1);
        bif.chan_write_valid[3] = 1'b0;
        repeat (3) step();
        check_val("t6_c2_pulses", 32'(rd_pulses[2] - b0), 32'd1);
        check_val("all_pulses_single_cycle", 32'(long_pulses), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
